carfield_domain_seq: RTL and testbench

Power-domain sequencer for the six clock-gateable Carfield subdomains: periph, safety island, security island, integer cluster, FP cluster and L2. It sits between the Carfield control registers, which hold per-domain enable requests, and the per-domain clock gates, reset generators and AXI isolation cells. It serves one domain transition at a time, choosing the next domain by round-robin arbitration. Its `clk_en_o` and `rst_n_o` vectors drive the domain clocks and resets, and the same signals appear on the debug-signal port.

---
 rtl/carfield_pkg.sv | 37 +++
 rtl/carfield_domain_seq_if.sv | 30 +++
 rtl/carfield_domain_seq_arb.sv | 32 +++
 rtl/carfield_domain_seq.sv | 197 +++++++++++++++++++
 tb/tb_carfield_domain_seq.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/carfield_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// carfield_pkg : shared Carfield domain indices and domain-sequencer types
// Revision 1.0
// ----------------------------------------------------------------------------
package carfield_pkg;

  localparam int unsigned NumDomains = 6;

  typedef enum logic [2:0] {
    PeriphDomainIdx     = 3'd0,
    SafetyDomainIdx     = 3'd1,
    SecurityDomainIdx   = 3'd2,
    IntClusterDomainIdx = 3'd3,
    FPClusterDomainIdx  = 3'd4,
    L2DomainIdx         = 3'd5
  } carfield_domains_e;

  localparam int unsigned DomainClkSettleCycles  = 8;
  localparam int unsigned DomainRstHoldCycles    = 16;
  localparam int unsigned DomainIsoTimeoutCycles = 1024;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ON_CLK   = 3'd1,
    ON_RST   = 3'd2,
    ON_DEISO = 3'd3,
    OFF_ISO  = 3'd4,
    OFF_RST  = 3'd5
  } domain_seq_state_e;

  function automatic int unsigned seq_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/carfield_domain_seq_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// carfield_domain_seq_if : register/gate-side bundle of the domain sequencer
// Revision 1.0
// ----------------------------------------------------------------------------
interface carfield_domain_seq_if #(
  parameter int unsigned NumDomains = carfield_pkg::NumDomains
);

  logic [NumDomains-1:0] en_req_i;
  logic [NumDomains-1:0] isolated_i;
  logic [NumDomains-1:0] clk_en_o;
  logic [NumDomains-1:0] rst_n_o;
  logic [NumDomains-1:0] isolate_o;
  logic [NumDomains-1:0] active_o;
  logic                  busy_o;
  logic [NumDomains-1:0] timeout_o;

  modport master (
    input  en_req_i, isolated_i,
    output clk_en_o, rst_n_o, isolate_o, active_o, busy_o, timeout_o
  );

  modport slave (
    output en_req_i, isolated_i,
    input  clk_en_o, rst_n_o, isolate_o, active_o, busy_o, timeout_o
  );

endinterface
`default_nettype wire

// File: rtl/carfield_domain_seq_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// carfield_domain_seq_arb : combinational round-robin picker (first pending at/after ptr)
// Revision 1.0
// ----------------------------------------------------------------------------
module carfield_domain_seq_arb #(
  parameter  int unsigned NumDomains = carfield_pkg::NumDomains,
  localparam int unsigned IdxW       = $clog2(NumDomains)
) (
  input  logic [NumDomains-1:0] pending_i,
  input  logic [IdxW-1:0]       ptr_i,
  output logic                  valid_o,
  output logic [IdxW-1:0]       idx_o
);

  // Scan from the farthest candidate back to the pointer so the nearest one wins.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int k = int'(NumDomains) - 1; k >= 0; k--) begin
      int j;
      j = int'(ptr_i) + k;
      if (j >= int'(NumDomains)) j = j - int'(NumDomains);
      if (pending_i[j[IdxW-1:0]]) begin
        valid_o = 1'b1;
        idx_o   = j[IdxW-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/carfield_domain_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// carfield_domain_seq : round-robin power-domain sequencer (clock, reset, isolation)
// Optional isolation-ack timeout: CARFIELD_DOMAIN_SEQ_TIMEOUT_EN   Revision 1.0
// ----------------------------------------------------------------------------
module carfield_domain_seq #(
  parameter int unsigned NumDomains      = carfield_pkg::NumDomains,
  parameter int unsigned ClkSettleCycles = carfield_pkg::DomainClkSettleCycles,
`ifdef CARFIELD_DOMAIN_SEQ_TIMEOUT_EN
  parameter int unsigned TimeoutCycles   = carfield_pkg::DomainIsoTimeoutCycles,
`endif
  parameter int unsigned RstHoldCycles   = carfield_pkg::DomainRstHoldCycles
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  carfield_domain_seq_if.master         ctrl_io
);

  import carfield_pkg::*;

  localparam int unsigned IdxW = $clog2(NumDomains);
`ifdef CARFIELD_DOMAIN_SEQ_TIMEOUT_EN
  localparam int unsigned CntMax = seq_max(seq_max(ClkSettleCycles, RstHoldCycles), TimeoutCycles);
`else
  localparam int unsigned CntMax = seq_max(ClkSettleCycles, RstHoldCycles);
`endif
  localparam int unsigned CntW = $clog2(CntMax + 1);

  // Counter loads are N-1 so a state lasts exactly N cycles including entry.
  localparam logic [CntW-1:0] ClkLoad  = CntW'(ClkSettleCycles - 1);
  localparam logic [CntW-1:0] RstLoad  = CntW'(RstHoldCycles - 1);
`ifdef CARFIELD_DOMAIN_SEQ_TIMEOUT_EN
  localparam logic [CntW-1:0] WaitLoad = CntW'(TimeoutCycles - 1);
`else
  localparam logic [CntW-1:0] WaitLoad = '0;
`endif
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(NumDomains - 1);

  domain_seq_state_e     state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [IdxW-1:0]       ptr_q, ptr_d;
  logic [NumDomains-1:0] clk_en_q, clk_en_d;
  logic [NumDomains-1:0] rst_n_q, rst_n_d;
  logic [NumDomains-1:0] iso_q, iso_d;
  logic [NumDomains-1:0] active_q, active_d;
`ifdef CARFIELD_DOMAIN_SEQ_TIMEOUT_EN
  logic [NumDomains-1:0] timeout_q, timeout_d;
`endif

  logic [NumDomains-1:0] pending;
  logic                  grant_valid;
  logic [IdxW-1:0]       grant_idx;
  logic                  cnt_zero;
  logic                  ack_on;
  logic                  ack_off;
  logic                  expire;

  assign pending  = ctrl_io.en_req_i ^ active_q;
  assign cnt_zero = (cnt_q == '0);
  assign ack_on   = ~ctrl_io.isolated_i[idx_q];
  assign ack_off  = ctrl_io.isolated_i[idx_q];
`ifdef CARFIELD_DOMAIN_SEQ_TIMEOUT_EN
  assign expire   = cnt_zero;
`else
  assign expire   = 1'b0;
`endif

  carfield_domain_seq_arb #(
    .NumDomains (NumDomains)
  ) i_arb (
    .pending_i  (pending),
    .ptr_i      (ptr_q),
    .valid_o    (grant_valid),
    .idx_o      (grant_idx)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      ptr_q     <= '0;
      clk_en_q  <= '0;
      rst_n_q   <= '0;
      iso_q     <= '1;
      active_q  <= '0;
`ifdef CARFIELD_DOMAIN_SEQ_TIMEOUT_EN
      timeout_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      clk_en_q  <= clk_en_d;
      rst_n_q   <= rst_n_d;
      iso_q     <= iso_d;
      active_q  <= active_d;
`ifdef CARFIELD_DOMAIN_SEQ_TIMEOUT_EN
      timeout_q <= timeout_d;
`endif
    end
  end

  // The target direction is captured by which path IDLE branches into.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) state_d = ctrl_io.en_req_i[grant_idx] ? ON_CLK : OFF_ISO;
      end
      ON_CLK:   if (cnt_zero)           state_d = ON_RST;
      ON_RST:   if (cnt_zero)           state_d = ON_DEISO;
      ON_DEISO: if (ack_on || expire)   state_d = IDLE;
      OFF_ISO:  if (ack_off || expire)  state_d = OFF_RST;
      OFF_RST:  if (cnt_zero)           state_d = IDLE;
      default:                          state_d = IDLE;
    endcase
  end

  // Output registers change only on state entry, so every output is a flop.
  always_comb begin
    cnt_d    = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    idx_d    = idx_q;
    ptr_d    = ptr_q;
    clk_en_d = clk_en_q;
    rst_n_d  = rst_n_q;
    iso_d    = iso_q;
    active_d = active_q;
`ifdef CARFIELD_DOMAIN_SEQ_TIMEOUT_EN
    timeout_d = timeout_q;
`endif

    if (state_d != state_q) begin
      case (state_d)
        ON_CLK: begin
          clk_en_d[grant_idx] = 1'b1;
          cnt_d               = ClkLoad;
        end
        ON_RST: begin
          rst_n_d[idx_q] = 1'b1;
          cnt_d          = RstLoad;
        end
        ON_DEISO: begin
          iso_d[idx_q] = 1'b0;
          cnt_d        = WaitLoad;
        end
        OFF_ISO: begin
          iso_d[grant_idx] = 1'b1;
          cnt_d            = WaitLoad;
        end
        OFF_RST: begin
          rst_n_d[idx_q] = 1'b0;
          cnt_d          = RstLoad;
        end
        IDLE: begin
          if (state_q == ON_DEISO) begin
            active_d[idx_q] = 1'b1;
          end else begin
            clk_en_d[idx_q] = 1'b0;
            active_d[idx_q] = 1'b0;
          end
        end
        default: cnt_d = cnt_q;
      endcase
    end

    if ((state_q == IDLE) && grant_valid) begin
      idx_d = grant_idx;
      ptr_d = (grant_idx == LastIdx) ? '0 : grant_idx + 1'b1;
`ifdef CARFIELD_DOMAIN_SEQ_TIMEOUT_EN
      timeout_d[grant_idx] = 1'b0;
`endif
    end

`ifdef CARFIELD_DOMAIN_SEQ_TIMEOUT_EN
    // An acknowledge arriving on the expiry cycle still counts as on time.
    if (expire && (((state_q == ON_DEISO) && !ack_on) || ((state_q == OFF_ISO) && !ack_off))) begin
      timeout_d[idx_q] = 1'b1;
    end
`endif
  end

  assign ctrl_io.clk_en_o  = clk_en_q;
  assign ctrl_io.rst_n_o   = rst_n_q;
  assign ctrl_io.isolate_o = iso_q;
  assign ctrl_io.active_o  = active_q;
  assign ctrl_io.busy_o    = (state_q != IDLE);
`ifdef CARFIELD_DOMAIN_SEQ_TIMEOUT_EN
  assign ctrl_io.timeout_o = timeout_q;
`else
  assign ctrl_io.timeout_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_carfield_domain_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_carfield_domain_seq : self-checking bench, transition timeline model vs DUT
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_carfield_domain_seq;

  localparam int N   = 6;
  localparam int CS  = 4;
  localparam int RH  = 8;
  localparam int LAT = 2;
  localparam int TO  = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  carfield_domain_seq_if #(.NumDomains(N)) dut_if ();

  carfield_domain_seq #(
    .NumDomains      (N),
    .ClkSettleCycles (CS),
`ifdef CARFIELD_DOMAIN_SEQ_TIMEOUT_EN
    .TimeoutCycles   (TO),
`endif
    .RstHoldCycles   (RH)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .ctrl_io (dut_if.master)
  );

  // Isolation cells: acknowledge follows the request two cycles later.
  logic [N-1:0] iso_d1, iso_d2, stuck_hi;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iso_d1 <= '1;
      iso_d2 <= '1;
    end else begin
      iso_d1 <= dut_if.isolate_o;
      iso_d2 <= iso_d1;
    end
  end
  assign dut_if.isolated_i = iso_d2 | stuck_hi;

  // Transition log: sig 0 clk_en, 1 rst_n, 2 isolate, 3 active, 4 busy.
  typedef struct {
    int   cyc;
    int   sig;
    int   dom;
    logic val;
  } ev_t;

  ev_t got_q[$];
  ev_t exp_q[$];
  logic [N-1:0] prev_v [4];
  logic         prev_busy;

  always @(negedge clk) begin
    logic [N-1:0] cur_v [4];
    ev_t ev;
    cur_v[0] = dut_if.clk_en_o;
    cur_v[1] = dut_if.rst_n_o;
    cur_v[2] = dut_if.isolate_o;
    cur_v[3] = dut_if.active_o;
    for (int s = 0; s < 4; s++)
      for (int d = 0; d < N; d++)
        if (cur_v[s][d] !== prev_v[s][d]) begin
          ev.cyc = cyc; ev.sig = s; ev.dom = d; ev.val = cur_v[s][d];
          got_q.push_back(ev);
        end
    if (dut_if.busy_o !== prev_busy) begin
      ev.cyc = cyc; ev.sig = 4; ev.dom = 0; ev.val = dut_if.busy_o;
      got_q.push_back(ev);
    end
    prev_v    = cur_v;
    prev_busy = dut_if.busy_o;
  end

  // Reference: abstract domain state plus round-robin pointer, producing a timeline.
  logic [N-1:0] act_m;
  int           ptr_m;

  function automatic void model_reset();
    act_m = '0;
    ptr_m = 0;
  endfunction

  function automatic void push_exp(input int c, input int s, input int d, input logic v);
    ev_t ev;
    ev.cyc = c; ev.sig = s; ev.dom = d; ev.val = v;
    exp_q.push_back(ev);
  endfunction

  function automatic int model_run(input int g0, input logic [N-1:0] req);
    int g;
    int d;
    logic [N-1:0] pend;
    g = g0;
    exp_q.delete();
    forever begin
      pend = req ^ act_m;
      if (pend == '0) break;
      d = -1;
      for (int k = 0; k < N; k++)
        if (d < 0 && pend[(ptr_m + k) % N]) d = (ptr_m + k) % N;
      ptr_m = (d + 1) % N;
      if (req[d]) begin
        push_exp(g + 1, 0, d, 1'b1);
        push_exp(g + 1, 4, 0, 1'b1);
        push_exp(g + 1 + CS, 1, d, 1'b1);
        push_exp(g + 1 + CS + RH, 2, d, 1'b0);
        g = g + 1 + CS + RH + LAT + 1;
        push_exp(g, 3, d, 1'b1);
        push_exp(g, 4, 0, 1'b0);
        act_m[d] = 1'b1;
      end else begin
        push_exp(g + 1, 2, d, 1'b1);
        push_exp(g + 1, 4, 0, 1'b1);
        push_exp(g + 2 + LAT, 1, d, 1'b0);
        g = g + 2 + LAT + RH;
        push_exp(g, 0, d, 1'b0);
        push_exp(g, 3, d, 1'b0);
        push_exp(g, 4, 0, 1'b0);
        act_m[d] = 1'b0;
      end
    end
    return g;
  endfunction

  function automatic string ev_str(input ev_t e);
    return $sformatf("cyc+%0d sig%0d dom%0d val%0b", e.cyc, e.sig, e.dom, e.val);
  endfunction

  function automatic string got_str(input int i);
    return (i < got_q.size()) ? ev_str(got_q[i]) : "none";
  endfunction

  function automatic bit ev_match(input int i);
    if (i >= got_q.size()) return 1'b0;
    return got_q[i].cyc == exp_q[i].cyc && got_q[i].sig == exp_q[i].sig &&
           got_q[i].dom == exp_q[i].dom && got_q[i].val === exp_q[i].val;
  endfunction

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
    #1;
  endtask

  // Applies a request at negedge+1; the DUT sees it in the current cycle.
  task automatic apply_req(input logic [N-1:0] req, output int g0);
    @(negedge clk);
    #1;
    got_q.delete();
    dut_if.en_req_i = req;
    g0 = cyc;
  endtask

  task automatic do_reset();
    dut_if.en_req_i = '0;
    stuck_hi        = '0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    wait_until(cyc + 3);
    n_chk++; if (dut_if.clk_en_o  !== 6'h00) begin n_err++; $display("FAIL reset clk_en: got %h want 00", dut_if.clk_en_o); end
    n_chk++; if (dut_if.rst_n_o   !== 6'h00) begin n_err++; $display("FAIL reset rst_n: got %h want 00", dut_if.rst_n_o); end
    n_chk++; if (dut_if.isolate_o !== 6'h3F) begin n_err++; $display("FAIL reset isolate: got %h want 3f", dut_if.isolate_o); end
    n_chk++; if (dut_if.active_o  !== 6'h00) begin n_err++; $display("FAIL reset active: got %h want 00", dut_if.active_o); end
    n_chk++; if (dut_if.busy_o    !== 1'b0)  begin n_err++; $display("FAIL reset busy: got %b want 0", dut_if.busy_o); end
    n_chk++; if (dut_if.timeout_o !== 6'h00) begin n_err++; $display("FAIL reset timeout: got %h want 00", dut_if.timeout_o); end
  endtask

  task automatic test_power_up();
    int g0, ge;
    apply_req(6'b001000, g0);
    ge = model_run(g0, 6'b001000);
    wait_until(ge + 3);
    n_chk++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL power_up count: got %0d want %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      n_chk++;
      if (!ev_match(i)) begin n_err++; $display("FAIL power_up ev%0d: got %s want %s (t=%0d)", i, got_str(i), ev_str(exp_q[i]), g0); end
    end
  endtask

  task automatic test_rr_pointer();
    int g0, ge;
    apply_req(6'b101010, g0);
    ge = model_run(g0, 6'b101010);
    wait_until(ge + 3);
    n_chk++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL rr_pointer count: got %0d want %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      n_chk++;
      if (!ev_match(i)) begin n_err++; $display("FAIL rr_pointer ev%0d: got %s want %s (t=%0d)", i, got_str(i), ev_str(exp_q[i]), g0); end
    end
  endtask

  task automatic test_power_down();
    int g0, ge;
    apply_req(6'b100010, g0);
    ge = model_run(g0, 6'b100010);
    wait_until(ge + 3);
    n_chk++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL power_down count: got %0d want %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      n_chk++;
      if (!ev_match(i)) begin n_err++; $display("FAIL power_down ev%0d: got %s want %s (t=%0d)", i, got_str(i), ev_str(exp_q[i]), g0); end
    end
  endtask

  task automatic test_random();
    int g0, ge;
    logic [N-1:0] req;
    for (int r = 0; r < 6; r++) begin
      req = N'($urandom_range(0, (1 << N) - 1));
      apply_req(req, g0);
      ge = model_run(g0, req);
      wait_until(ge + 3);
      n_chk++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL random%0d count: got %0d want %0d (req %h)", r, got_q.size(), exp_q.size(), req); end
      foreach (exp_q[i]) begin
        n_chk++;
        if (!ev_match(i)) begin n_err++; $display("FAIL random%0d ev%0d: got %s want %s (t=%0d)", r, i, got_str(i), ev_str(exp_q[i]), g0); end
      end
      n_chk++; if (dut_if.active_o !== req) begin n_err++; $display("FAIL random%0d active: got %h want %h", r, dut_if.active_o, req); end
    end
  endtask

  task automatic test_all_six();
    int g0, ge;
    do_reset();
    apply_req(6'h3F, g0);
    ge = model_run(g0, 6'h3F);
    wait_until(ge + 3);
    n_chk++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL all_six count: got %0d want %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      n_chk++;
      if (!ev_match(i)) begin n_err++; $display("FAIL all_six ev%0d: got %s want %s (t=%0d)", i, got_str(i), ev_str(exp_q[i]), g0); end
    end
    n_chk++; if (dut_if.active_o !== 6'h3F || dut_if.busy_o !== 1'b0) begin n_err++; $display("FAIL all_six final: active %h busy %b want 3f/0", dut_if.active_o, dut_if.busy_o); end
  endtask

  task automatic test_no_ack();
    int g0, g1;
    do_reset();
    stuck_hi = 6'b000100;
    apply_req(6'b000100, g0);
`ifdef CARFIELD_DOMAIN_SEQ_TIMEOUT_EN
    wait_until(g0 + 1 + CS + RH + TO - 1);
    n_chk++; if (dut_if.active_o[2] !== 1'b0 || dut_if.timeout_o[2] !== 1'b0) begin n_err++; $display("FAIL timeout early: active %b timeout %b want 0/0", dut_if.active_o[2], dut_if.timeout_o[2]); end
    wait_until(g0 + 1 + CS + RH + TO);
    n_chk++; if (dut_if.active_o[2] !== 1'b1) begin n_err++; $display("FAIL timeout active: got %b want 1", dut_if.active_o[2]); end
    n_chk++; if (dut_if.timeout_o !== 6'b000100) begin n_err++; $display("FAIL timeout flag: got %h want 04", dut_if.timeout_o); end
    n_chk++; if (dut_if.busy_o !== 1'b0) begin n_err++; $display("FAIL timeout busy: got %b want 0", dut_if.busy_o); end
    apply_req(6'b000000, g1);
    wait_until(g1 + 1);
    n_chk++; if (dut_if.timeout_o[2] !== 1'b0) begin n_err++; $display("FAIL timeout clear on grant: got %b want 0", dut_if.timeout_o[2]); end
    wait_until(g1 + 2 + RH + 2);
    n_chk++; if (dut_if.active_o !== 6'h00 || dut_if.clk_en_o !== 6'h00) begin n_err++; $display("FAIL timeout power_down: active %h clk_en %h want 00/00", dut_if.active_o, dut_if.clk_en_o); end
`else
    wait_until(g0 + 1 + CS + RH + 100);
    n_chk++; if (dut_if.busy_o !== 1'b1) begin n_err++; $display("FAIL no_ack busy: got %b want 1", dut_if.busy_o); end
    n_chk++; if (dut_if.active_o !== 6'h00 || dut_if.timeout_o !== 6'h00) begin n_err++; $display("FAIL no_ack active/timeout: got %h/%h want 00/00", dut_if.active_o, dut_if.timeout_o); end
    g1 = cyc;
    stuck_hi = '0;
    wait_until(g1 + 1);
    n_chk++; if (dut_if.active_o !== 6'b000100 || dut_if.busy_o !== 1'b0) begin n_err++; $display("FAIL no_ack late ack: active %h busy %b want 04/0", dut_if.active_o, dut_if.busy_o); end
`endif
    stuck_hi = '0;
  endtask

  task automatic test_async_reset();
    int g0, g1, ge;
    do_reset();
    apply_req(6'b000010, g0);
    wait_until(g0 + 1 + CS + 2);
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (dut_if.clk_en_o !== 6'h00 || dut_if.rst_n_o !== 6'h00) begin n_err++; $display("FAIL async clk_en/rst_n: got %h/%h want 00/00", dut_if.clk_en_o, dut_if.rst_n_o); end
    n_chk++; if (dut_if.isolate_o !== 6'h3F || dut_if.active_o !== 6'h00) begin n_err++; $display("FAIL async isolate/active: got %h/%h want 3f/00", dut_if.isolate_o, dut_if.active_o); end
    n_chk++; if (dut_if.busy_o !== 1'b0 || dut_if.timeout_o !== 6'h00) begin n_err++; $display("FAIL async busy/timeout: got %b/%h want 0/00", dut_if.busy_o, dut_if.timeout_o); end
    wait_until(cyc + 2);
    got_q.delete();
    rst_n = 1'b1;
    g1 = cyc;
    model_reset();
    ge = model_run(g1, 6'b000010);
    wait_until(ge + 3);
    n_chk++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL async restart count: got %0d want %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      n_chk++;
      if (!ev_match(i)) begin n_err++; $display("FAIL async restart ev%0d: got %s want %s (t=%0d)", i, got_str(i), ev_str(exp_q[i]), g1); end
    end
  endtask

  initial begin
    dut_if.en_req_i = '0;
    stuck_hi        = '0;
    test_reset();
    test_power_up();
    test_rr_pointer();
    test_power_down();
    test_random();
    test_all_six();
    test_no_ack();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
